// File: rtl/fir_param_adapt.sv
// fir_param_adapt: FIR filter with runtime-loadable coefficients, optional saturation and output shift.
module fir_param_adapt #(
  parameter int TAPS   = 4,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 11,
  parameter int SHIFT  = 0,
  parameter int SAT_EN = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_n,
  input  logic                     s_axis_fir_tvalid,
  input  logic                     s_set_coeffs,
  output logic signed [OUT_W-1:0]  y_n,
  output logic                     m_axis_fir_tvalid,
  output logic                     coef_loading,
  output logic                     coef_done
);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int KW = $clog2(TAPS + 1);
  localparam int IW = $clog2(TAPS);
  localparam int EW = (ACC_W > OUT_W ? ACC_W : OUT_W) + 1;
  localparam logic signed [EW-1:0] ONE = 1;
  localparam logic signed [EW-1:0] HI = (ONE <<< (OUT_W - 1)) - ONE;
  localparam logic signed [EW-1:0] LO = -(ONE <<< (OUT_W - 1));
  typedef enum logic {RUN, LOAD} state_t;
  state_t state, state_next;
  logic [KW-1:0] k;
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [COEF_W-1:0] cw;
  logic signed [DATA_W-1:0] d [TAPS-1];
  logic signed [DATA_W-1:0] w [TAPS];
  logic signed [ACC_W-1:0] acc, sh;
  logic signed [EW-1:0] se;
  logic signed [OUT_W-1:0] y_next;
  always_ff @(posedge clk) state <= reset ? RUN : state_next;
  always_comb begin
    state_next = s_set_coeffs ? LOAD : RUN;
    coef_loading = state == LOAD;
  end
  assign cw = COEF_W'(x_n);
  // Window holds the incoming sample as x[n] so the output is ready on the accepting edge.
  always_comb begin
    w[0] = x_n;
    for (int i = 1; i < TAPS; i++) w[i] = d[i-1];
    acc = '0;
    for (int i = 0; i < TAPS; i++) acc = acc + ACC_W'(c[i]) * ACC_W'(w[i]);
    sh = acc >>> SHIFT;
    se = EW'(sh);
    y_next = (SAT_EN != 0 && se > HI) ? HI[OUT_W-1:0] :
             (SAT_EN != 0 && se < LO) ? LO[OUT_W-1:0] : se[OUT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      k <= '0;
      for (int i = 0; i < TAPS - 1; i++) d[i] <= '0;
      for (int i = 0; i < TAPS; i++) c[i] <= '0;
      c[0] <= COEF_W'(1);
      y_n <= '0;
      m_axis_fir_tvalid <= 1'b0;
      coef_done <= 1'b0;
    end else begin
      m_axis_fir_tvalid <= 1'b0;
      coef_done <= 1'b0;
      if (s_set_coeffs) begin
        if (k < KW'(TAPS)) begin
          c[k[IW-1:0]] <= cw;
          k <= k + KW'(1);
          coef_done <= k == KW'(TAPS - 1);
        end
      end else begin
        k <= '0;
        if (s_axis_fir_tvalid) begin
          for (int i = TAPS - 2; i > 0; i--) d[i] <= d[i-1];
          d[0] <= x_n;
          y_n <= y_next;
          m_axis_fir_tvalid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_param_adapt.sv
// tb_fir_param_adapt: directed vectors checked against an arithmetic FIR model every cycle.
module tb_fir_param_adapt;
  localparam int TAPS = 4;
  localparam int SHIFT = 0;
  localparam int HI = 1023;
  localparam int LO = -1024;
  logic clk = 0;
  logic reset = 1;
  logic signed [7:0] x_n = 0;
  logic tvalid = 0, set = 0;
  logic signed [10:0] y_n;
  logic vld, loading, done;
  int errs = 0, checks = 0;
  int mc [TAPS];
  int h [TAPS];
  int mk = 0, ey = 0, ev = 0, el = 0, ed = 0;
  bit go = 0;
  fir_param_adapt dut (
    .clk(clk), .reset(reset), .x_n(x_n), .s_axis_fir_tvalid(tvalid), .s_set_coeffs(set),
    .y_n(y_n), .m_axis_fir_tvalid(vld), .coef_loading(loading), .coef_done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  // Model: convolution over the accepted-sample history, clamped to the output range.
  task automatic model_step();
    int s;
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin mc[i] = (i == 0) ? 1 : 0; h[i] = 0; end
      mk = 0; ey = 0; ev = 0; el = 0; ed = 0; go = 1;
    end else begin
      ev = 0; ed = 0; el = set;
      if (set) begin
        if (mk < TAPS) begin mc[mk] = int'(x_n); mk++; ed = (mk == TAPS); end
      end else begin
        mk = 0;
        if (tvalid) begin
          for (int i = TAPS - 1; i > 0; i--) h[i] = h[i-1];
          h[0] = int'(x_n);
          s = 0;
          for (int i = 0; i < TAPS; i++) s += mc[i] * h[i];
          s = s >>> SHIFT;
          ey = s > HI ? HI : (s < LO ? LO : s);
          ev = 1;
        end
      end
    end
  endtask
  task automatic drive(input int x, input bit tv, input bit sc);
    x_n = 8'(x); tvalid = tv; set = sc;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic ld(input int x);
    drive(x, 0, 1);
  endtask
  task automatic smp(input string nm, input int x, input int e);
    drive(x, 1, 0);
    chk(nm, int'(y_n), e);
  endtask
  always @(negedge clk) if (go) begin
    chk("model_y", int'(y_n), ey);
    chk("model_vld", int'(vld), ev);
    chk("model_loading", int'(loading), el);
    chk("model_done", int'(done), ed);
  end
  initial begin
    int yh;
    drive(0, 0, 0);
    drive(0, 0, 0);
    reset = 0;
    chk("rst_y", int'(y_n), 0);
    chk("rst_vld", int'(vld), 0);
    chk("rst_loading", int'(loading), 0);
    chk("rst_done", int'(done), 0);
    smp("imp0", 1, 1); smp("imp1", 0, 0); smp("imp2", 0, 0); smp("imp3", 0, 0);
    ld(7); ld(-5); ld(27);
    chk("done_early", int'(done), 0);
    ld(3);
    chk("done_4th", int'(done), 1);
    chk("loading_hi", int'(loading), 1);
    drive(0, 0, 0);
    smp("ld0", 1, 7); smp("ld1", 0, -5); smp("ld2", 0, 27); smp("ld3", 0, 3); smp("ld4", 0, 0);
    for (int i = 0; i < 4; i++) ld(127);
    drive(0, 0, 0);
    for (int i = 0; i < 3; i++) drive(127, 1, 0);
    smp("sat_pos", 127, 1023);
    for (int i = 0; i < 4; i++) ld(127);
    drive(0, 0, 0);
    for (int i = 0; i < 3; i++) drive(-128, 1, 0);
    smp("sat_neg", -128, -1024);
    ld(7); ld(-5); ld(27); ld(3);
    drive(0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0);
    ld(10);
    chk("part_done0", int'(done), 0);
    ld(20);
    chk("part_done1", int'(done), 0);
    drive(0, 0, 0);
    chk("part_done2", int'(done), 0);
    smp("pl0", 1, 10); smp("pl1", 0, 20); smp("pl2", 0, 27); smp("pl3", 0, 3);
    ld(50); ld(60);
    reset = 1;
    drive(70, 0, 1);
    chk("rst_abort_loading", int'(loading), 0);
    reset = 0;
    set = 0;
    smp("ra0", 1, 1); smp("ra1", 0, 0); smp("ra2", 0, 0); smp("ra3", 0, 0);
    ld(1); ld(2); ld(3); ld(4);
    drive(0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0);
    smp("nogap0", 5, 5); smp("nogap1", -3, 7); smp("nogap2", 7, 16); smp("nogap3", 2, 27); smp("nogap4", 9, 22);
    for (int i = 0; i < 3; i++) drive(0, 1, 0);
    begin
      int xs [5] = '{5, -3, 7, 2, 9};
      int es [5] = '{5, 7, 16, 27, 22};
      for (int i = 0; i < 5; i++) begin
        smp("gap_out", xs[i], es[i]);
        yh = int'(y_n);
        for (int g = 0; g <= i; g++) begin
          drive(0, 0, 0);
          chk("gap_vld", int'(vld), 0);
          chk("gap_hold", int'(y_n), yh);
        end
      end
    end
    drive(1, 1, 1);
    chk("drop_vld", int'(vld), 0);
    smp("drop_next", 0, 52);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fir_param_adapt.md
FIR_PARAM_ADAPT -- requirements
Module: fir_param_adapt

Interface
REQ-001 SHALL provide parameter TAPS, default 4, number of filter taps (2..16).
REQ-002 SHALL provide parameter DATA_W, default 8, signed input sample width.
REQ-003 SHALL provide parameter COEF_W, default 8, signed coefficient width.
REQ-004 SHALL provide parameter OUT_W, default 11, signed output width.
REQ-005 SHALL provide parameter SHIFT, default 0, arithmetic right shift applied to the accumulator before output.
REQ-006 SHALL provide parameter SAT_EN, default 1; 1 = saturate to OUT_W, 0 = two's-complement wrap.
REQ-007 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-008 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL provide port x_n  input  DATA_W  signed sample in run mode; signed coefficient word in load mode (low COEF_W bits, sign-extended or truncated).
REQ-010 SHALL provide port s_axis_fir_tvalid  input  1  sample valid.
REQ-011 SHALL provide port s_set_coeffs  input  1  coefficient-load request, level-sensitive.
REQ-012 SHALL provide port y_n  output  OUT_W  signed filter output, registered.
REQ-013 SHALL provide port m_axis_fir_tvalid  output  1  one-cycle pulse per output sample.
REQ-014 SHALL provide port coef_loading  output  1  high while in LOAD state.
REQ-015 SHALL provide port coef_done  output  1  one-cycle pulse when all TAPS coefficients have been written.

Function
REQ-016 SHALL implement states RUN and LOAD; RUN->LOAD when s_set_coeffs=1; LOAD->RUN when s_set_coeffs=0.
REQ-017 In LOAD, each cycle SHALL write x_n into c[k], k = load counter (0 first), then increment k.
REQ-018 When k reaches TAPS, coef_done SHALL pulse on that write; further words SHALL be ignored until s_set_coeffs drops.
REQ-019 Early deassertion (k<TAPS) SHALL keep the written words, leave c[k..TAPS-1] unchanged and clear k; no coef_done.
REQ-020 The load counter SHALL reset to 0 on every LOAD entry.
REQ-021 In RUN with s_axis_fir_tvalid=1 a sample SHALL be accepted: delay line shifts (d[0]<=x_n, d[i]<=d[i-1]).
REQ-022 On the accepting edge, y_n SHALL register sum_{k=0..TAPS-1} c[k]*x[n-k], using the new x_n as x[n]; m_axis_fir_tvalid SHALL be 1 in the following cycle only (latency 1).
REQ-023 Accumulation SHALL be full precision (DATA_W+COEF_W+ceil(log2 TAPS) bits), then arithmetic shift right by SHIFT (truncate toward -inf).
REQ-024 With SAT_EN=1 the result SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; with SAT_EN=0 it SHALL keep the low OUT_W bits.
REQ-025 When s_axis_fir_tvalid=0, delay line and y_n SHALL hold and m_axis_fir_tvalid SHALL be 0.
REQ-026 With s_set_coeffs=1 and s_axis_fir_tvalid=1 together, load SHALL win; the sample SHALL be dropped; no output pulse.
REQ-027 A coefficient change SHALL not clear the delay line; the next output uses new coefficients on old history.

Reset
REQ-028 On reset: state RUN, load counter 0, delay line all 0, c[0]=1 and c[1..TAPS-1]=0 (identity filter).
REQ-029 On reset: y_n=0, m_axis_fir_tvalid=0, coef_loading=0, coef_done=0.
REQ-030 Reset during LOAD SHALL abort the load and restore the default coefficients.

Verification (defaults: TAPS=4, DATA_W=8, COEF_W=8, OUT_W=11, SHIFT=0, SAT_EN=1)
REQ-031 Reset, then impulse x=1 followed by zeros, tvalid=1 throughout -> y_n = 1,0,0,0; one m_axis_fir_tvalid pulse per sample.
REQ-032 Load 7,-5,27,3 (s_set_coeffs high 4 cycles), then impulse 1 -> y_n = 7,-5,27,3,0; coef_done pulses on the 4th word.
REQ-033 Load 127 x4, feed x=127 for 4 samples -> 4th output clamps to 1023; load 127 x4, feed -128 for 4 samples -> 4th output clamps to -1024.
REQ-034 After REQ-032, s_set_coeffs high 2 cycles with 10,20 -> coefficients 10,20,27,3; impulse gives 10,20,27,3; no coef_done.
REQ-035 Assert reset after 2 load words -> coef_loading=0; impulse gives 1,0,0,0.
REQ-036 tvalid gaps of 1-5 cycles between samples -> y_n holds, no pulse during gaps, outputs identical to gap-free run; tvalid=1 together with s_set_coeffs -> no output pulse, sample dropped.
